cam_packet_feeder: RTL and testbench

CAM_PACKET_FEEDER -- requirements
Module: cam_packet_feeder

---
 rtl/cam_packet_feeder.sv | 153 +++++++++++++++
 tb/tb_cam_packet_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_packet_feeder.sv
// Bus-event FIFO feeding a serializer one 32-bit word per IDLE->WRITE->SETTLE cycle.
// Optional idle heartbeat word enabled by defining CAM_FEEDER_HEARTBEAT_EN.
module cam_packet_feeder #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned HB_CYCLES = 1000000
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   ev_valid_i,
    input  logic [15:0]            ev_addr_i,
    input  logic [7:0]             ev_data_i,
    output logic                   ev_ready_o,
    input  logic                   busy_i,
    output logic                   wr_o,
    output logic [31:0]            data_o,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   overflow_o
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SETTLE
    } state_t;

    state_t         state_q, state_d;
    logic [23:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic [3:0]     seq_q;
    logic           full, empty;
    logic           push, pop;
    logic           issue, issue_hb;
    logic           hb_due;
    logic [31:0]    word_d;

    // Illegal parameter combinations leave this block empty-bodied; kept as a visible anchor
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || HB_CYCLES < 2) begin : g_param_check
    end

    assign full         = (count_q == FULL_COUNT);
    assign empty        = (count_q == '0);
    assign ev_ready_o   = !full;
    assign fifo_count_o = count_q;
    assign push         = ev_valid_i && !full;
    assign pop          = issue && !issue_hb;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= {ev_addr_i, ev_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
        end else if (ev_valid_i && full) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef CAM_FEEDER_HEARTBEAT_EN
    logic [31:0] hb_cnt_q;

    assign hb_due = (hb_cnt_q == 32'(HB_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
        end else if (issue) begin
            hb_cnt_q <= '0;
        end else if (state_q == IDLE && empty && !busy_i) begin
            hb_cnt_q <= hb_cnt_q + 32'd1;
        end
    end
`else
    assign hb_due = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Events always win over a due heartbeat; SETTLE gives busy_i time to reflect the write
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        issue_hb = 1'b0;
        case (state_q)
            IDLE: begin
                if (!busy_i) begin
                    if (!empty) begin
                        issue = 1'b1;
                    end else if (hb_due) begin
                        issue    = 1'b1;
                        issue_hb = 1'b1;
                    end
                end
                if (issue) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign word_d = issue_hb ? {4'hF, seq_q, 24'h000000}
                             : {4'h1, seq_q, mem[rd_ptr_q]};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_o   <= 1'b0;
            data_o <= '0;
            seq_q  <= '0;
        end else begin
            wr_o <= issue;
            if (issue) begin
                data_o <= word_d;
                seq_q  <= seq_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cam_packet_feeder.sv
// Self-checking bench for cam_packet_feeder: vector table, directed corner cases and a
// randomized run scored against a queue-based reference model.
module tb_cam_packet_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HB    = 8;
`ifdef CAM_FEEDER_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    logic        clk_i      = 1'b0;
    logic        rst_n      = 1'b0;
    logic        ev_valid_i = 1'b0;
    logic [15:0] ev_addr_i  = '0;
    logic [7:0]  ev_data_i  = '0;
    logic        busy_i     = 1'b0;
    logic        ev_ready_o;
    logic        wr_o;
    logic [31:0] data_o;
    logic [$clog2(DEPTH):0] fifo_count_o;
    logic        overflow_o;

    always #5 clk_i = ~clk_i;

    cam_packet_feeder #(
        .DEPTH     (DEPTH),
        .HB_CYCLES (HB)
    ) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .ev_valid_i   (ev_valid_i),
        .ev_addr_i    (ev_addr_i),
        .ev_data_i    (ev_data_i),
        .ev_ready_o   (ev_ready_o),
        .busy_i       (busy_i),
        .wr_o         (wr_o),
        .data_o       (data_o),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted events, word counter, cycles since last write
    logic [23:0] mq[$];
    logic [3:0]  m_seq;
    bit          m_ovf;
    int          m_since;
    int          m_idle;
    logic [31:0] m_data;
    logic        saw_wr;
    logic [31:0] saw_data;
    logic        saw_busy;

    task automatic model_reset();
        mq.delete();
        m_seq   = '0;
        m_ovf   = 1'b0;
        m_since = 2;
        m_idle  = 0;
        m_data  = '0;
    endtask

    task automatic drive(input bit v, input logic [15:0] a, input logic [7:0] d, input bit b);
        ev_valid_i = v;
        ev_addr_i  = a;
        ev_data_i  = d;
        busy_i     = b;
    endtask

    task automatic step();
        logic        v;
        logic [23:0] ev;
        logic        b;
        int          size_pre;
        bit          idle_pre;
        bit          ew;
        logic [31:0] eword;
        v        = ev_valid_i;
        ev       = {ev_addr_i, ev_data_i};
        b        = busy_i;
        size_pre = mq.size();
        idle_pre = (m_since >= 2);
        ew       = 1'b0;
        eword    = m_data;
        if (idle_pre && !b) begin
            if (size_pre > 0) begin
                ew    = 1'b1;
                eword = {4'h1, m_seq, mq.pop_front()};
            end else if (HB_EN && m_idle == int'(HB) - 1) begin
                ew    = 1'b1;
                eword = {4'hF, m_seq, 24'h000000};
            end
        end
        if (ew) m_idle = 0;
        else if (HB_EN && idle_pre && !b && size_pre == 0) m_idle++;
        if (v) begin
            if (size_pre < int'(DEPTH)) mq.push_back(ev);
            else m_ovf = 1'b1;
        end
        if (ew) begin
            m_since = 0;
            m_seq   = m_seq + 4'd1;
            m_data  = eword;
        end else if (m_since < 100) begin
            m_since++;
        end
        @(posedge clk_i);
        #1;
        chk("model_wr_o", 32'(wr_o), 32'(ew));
        chk("model_data_o", data_o, m_data);
        chk("model_fifo_count", 32'(fifo_count_o), 32'(mq.size()));
        chk("model_ev_ready", 32'(ev_ready_o), 32'(mq.size() < int'(DEPTH)));
        chk("model_overflow", 32'(overflow_o), 32'(m_ovf));
        saw_wr   = wr_o;
        saw_data = data_o;
        saw_busy = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_wr_o", 32'(wr_o), 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_fifo_count", 32'(fifo_count_o), 32'd0);
        chk("rst_ev_ready", 32'(ev_ready_o), 32'd1);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          v;
        logic [15:0] a;
        logic [7:0]  d;
        bit          b;
        bit          exp_wr;
        logic [31:0] exp_data;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          got;
        int          pct;
        int          busy_left;
        bit          pend;
        int          sent;
        logic [31:0] w[17];
        int          hit_edge[3];
        logic [31:0] hit_data[3];
        int          nhits;
        int          pcts[4];

        tbl[0] = '{1'b1, 16'hC030, 8'h5A, 1'b0, 1'b0, 32'h00000000, 1};
        tbl[1] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 32'h10C0305A, 0};
        tbl[2] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 32'h10C0305A, 0};
        tbl[3] = '{1'b1, 16'h1234, 8'h77, 1'b0, 1'b0, 32'h10C0305A, 1};
        tbl[4] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 32'h11123477, 0};
        tbl[5] = '{1'b1, 16'hABCD, 8'h01, 1'b1, 1'b0, 32'h11123477, 1};
        tbl[6] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 32'h11123477, 1};
        tbl[7] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 32'h11123477, 1};
        tbl[8] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 32'h12ABCD01, 0};
        tbl[9] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 32'h12ABCD01, 0};
        pcts = '{0, 15, 50, 90};

        // Vector table: single-event latency, 3-cycle spacing, busy hold
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].b);
            step();
            chk($sformatf("tbl%0d_wr", i), 32'(saw_wr), 32'(tbl[i].exp_wr));
            chk($sformatf("tbl%0d_data", i), saw_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_count", i), 32'(fifo_count_o), 32'(tbl[i].exp_cnt));
        end

        // Overflow with busy held, then drain in order
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(32'h3000 + i), 8'(i), 1'b1);
            step();
            chk("ovf_no_wr_while_busy", 32'(saw_wr), 32'd0);
            if (i == 15) chk("ovf_ready_after16", 32'(ev_ready_o), 32'd0);
        end
        chk("ovf_count16", 32'(fifo_count_o), 32'd16);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        drive(1'b0, '0, '0, 1'b0);
        got = 0;
        for (int c = 0; c < 100 && got < 16; c++) begin
            step();
            if (saw_wr) begin
                chk("ovf_drain_word", saw_data,
                    {4'h1, 4'(got), 16'(32'h3000 + got), 8'(got)});
                got++;
            end
        end
        chk("ovf_drained16", 32'(got), 32'd16);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Serializer with 40-cycle packets, 17 events, seq wrap
        do_reset();
        busy_left = 0;
        pend      = 1'b0;
        sent      = 0;
        got       = 0;
        for (int c = 0; c < 1000 && got < 17; c++) begin
            drive(sent < 17, 16'(32'h2000 + sent), 8'(sent), busy_left > 0);
            step();
            if (sent < 17) sent++;
            if (saw_wr) begin
                chk("ser_wr_with_busy", 32'(saw_busy), 32'd0);
                if (got < 17) w[got] = saw_data;
                got++;
            end
            if (busy_left > 0) busy_left--;
            if (pend) busy_left = 40;
            pend = saw_wr;
        end
        chk("ser_words17", 32'(got), 32'd17);
        for (int j = 0; j < 17 && j < got; j++) begin
            chk($sformatf("ser_word%0d", j), w[j], {4'h1, 4'(j), 16'(32'h2000 + j), 8'(j)});
        end
        chk("ser_seq15", 32'(w[15][27:24]), 32'd15);
        chk("ser_seq_wrap0", 32'(w[16][27:24]), 32'd0);
        chk("ser_no_overflow", 32'(overflow_o), 32'd0);

        // Simultaneous push and pop at count 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(32'h0100 + i), 8'(32'h10 + i), 1'b1);
            step();
        end
        drive(1'b0, '0, '0, 1'b1);
        step();
        chk("pp_count3_before", 32'(fifo_count_o), 32'd3);
        drive(1'b1, 16'h0103, 8'h13, 1'b0);
        step();
        chk("pp_wr", 32'(saw_wr), 32'd1);
        chk("pp_count3_after", 32'(fifo_count_o), 32'd3);
        chk("pp_word0", saw_data, 32'h10010010);
        drive(1'b0, '0, '0, 1'b0);
        got = 1;
        for (int c = 0; c < 30 && got < 4; c++) begin
            step();
            if (saw_wr) begin
                chk("pp_order", saw_data,
                    {4'h1, 4'(got), 16'(32'h0100 + got), 8'(32'h10 + got)});
                got++;
            end
        end
        chk("pp_drained", 32'(got), 32'd4);

        // Reset asserted while in WRITE
        do_reset();
        drive(1'b1, 16'h0A0A, 8'hA0, 1'b0);
        step();
        drive(1'b1, 16'h0B0B, 8'hB0, 1'b0);
        step();
        chk("rstw_in_write", 32'(saw_wr), 32'd1);
        drive(1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_wr_low", 32'(wr_o), 32'd0);
        chk("rstw_count0", 32'(fifo_count_o), 32'd0);
        chk("rstw_data0", data_o, 32'd0);
        chk("rstw_ready", 32'(ev_ready_o), 32'd1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rstw_no_pulse", 32'(saw_wr), 32'd0);
        end

        // Idle heartbeat (or its absence)
        do_reset();
        nhits = 0;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (saw_wr) begin
                if (nhits < 3) begin
                    hit_edge[nhits] = e;
                    hit_data[nhits] = saw_data;
                end
                nhits++;
            end
        end
`ifdef CAM_FEEDER_HEARTBEAT_EN
        chk("hb_count", 32'(nhits), 32'd3);
        for (int k = 0; k < 3 && k < nhits; k++) begin
            chk($sformatf("hb%0d_edge", k), 32'(hit_edge[k]), 32'(8 + 10 * k));
            chk($sformatf("hb%0d_word", k), hit_data[k], {4'hF, 4'(k), 24'h000000});
        end
`else
        chk("hb_absent", 32'(nhits), 32'd0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) pct = pcts[$urandom_range(0, 3)];
            drive($urandom_range(0, 99) < pct, 16'($urandom), 8'($urandom),
                  $urandom_range(0, 9) < 3);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
